// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-reader port, pipeline control inputs, IF/ID register and status outputs.
// master is the fetch stage itself; slave is the reader/decode/control environment around it.
interface fetch_stage_if #(
  parameter int PC_SIZE    = 32,
  parameter int INSTR_SIZE = 32,
  parameter int COUNT_SIZE = 32
);
  logic [PC_SIZE-1:0]    pc_o;
  logic [INSTR_SIZE-1:0] instr_i;
  logic                  done_i;
  logic                  stall_i;
  logic                  flush_i;
  logic                  redirect_valid_i;
  logic [PC_SIZE-1:0]    redirect_pc_i;
  logic                  if_id_valid_o;
  logic [INSTR_SIZE-1:0] if_id_instr_o;
  logic [PC_SIZE-1:0]    if_id_pc_o;
  logic [PC_SIZE-1:0]    if_id_pc_plus4_o;
  logic                  halted_o;
  logic                  misalign_o;
  logic [COUNT_SIZE-1:0] fetch_count_o;

  modport master (
    output pc_o,
    input  instr_i, done_i, stall_i, flush_i, redirect_valid_i, redirect_pc_i,
    output if_id_valid_o, if_id_instr_o, if_id_pc_o, if_id_pc_plus4_o,
    output halted_o, misalign_o, fetch_count_o
  );

  modport slave (
    input  pc_o,
    output instr_i, done_i, stall_i, flush_i, redirect_valid_i, redirect_pc_i,
    input  if_id_valid_o, if_id_instr_o, if_id_pc_o, if_id_pc_plus4_o,
    input  halted_o, misalign_o, fetch_count_o
  );
endinterface

// File: rtl/fetch_stage.sv
// Fetch front-end: owns the PC, reads the combinational instruction reader and fills the IF/ID register.
// Priority per edge: reset > redirect > flush > stall > done > normal fetch.
module fetch_stage #(
  parameter int                     PC_SIZE    = 32,
  parameter int                     INSTR_SIZE = 32,
  parameter logic [PC_SIZE-1:0]     RESET_PC   = '0,
  parameter logic [INSTR_SIZE-1:0]  NOP_INSTR  = '0,
  parameter int                     COUNT_SIZE = 32
) (
  input logic           clk_i,
  input logic           rst_n_i,
  fetch_stage_if.master bus
);

  typedef enum logic {RUN, HALTED} state_e;

  state_e                state, state_next;
  logic [PC_SIZE-1:0]    pc, pc_next, pc_plus4;
  logic                  capture, invalidate;
  logic                  halted;
  logic                  if_id_valid;
  logic [INSTR_SIZE-1:0] if_id_instr;
  logic [PC_SIZE-1:0]    if_id_pc, if_id_pc_plus4;
  logic                  misalign;
  logic [COUNT_SIZE-1:0] fetch_count;

  assign pc_plus4 = pc + PC_SIZE'(4);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values;
  // combinational blocks use blocking (=) and assign a default first so no latch is inferred.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= RUN;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.redirect_valid_i)
      state_next = RUN;
    else if (state == RUN && !bus.flush_i && !bus.stall_i && bus.done_i)
      state_next = HALTED;
  end

  always_comb begin
    halted = (state == HALTED);
  end

  // PC and IF/ID control; HALTED swallows stall/flush/done so only a redirect can move the PC.
  always_comb begin
    pc_next    = pc;
    capture    = 1'b0;
    invalidate = 1'b0;
    if (bus.redirect_valid_i) begin
      pc_next    = {bus.redirect_pc_i[PC_SIZE-1:2], 2'b00};
      invalidate = 1'b1;
    end else if (state == HALTED) begin
      invalidate = 1'b1;
    end else if (bus.flush_i) begin
      invalidate = 1'b1;
      if (!bus.stall_i) pc_next = pc_plus4;
    end else if (bus.stall_i) begin
      pc_next = pc;
    end else if (bus.done_i) begin
      invalidate = 1'b1;
    end else begin
      capture = 1'b1;
      pc_next = pc_plus4;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pc             <= RESET_PC;
      if_id_valid    <= 1'b0;
      if_id_instr    <= NOP_INSTR;
      if_id_pc       <= '0;
      if_id_pc_plus4 <= PC_SIZE'(4);
      misalign       <= 1'b0;
      fetch_count    <= '0;
    end else begin
      pc <= pc_next;
      if (capture) begin
        if_id_valid    <= 1'b1;
        if_id_instr    <= bus.instr_i;
        if_id_pc       <= pc;
        if_id_pc_plus4 <= pc_plus4;
        fetch_count    <= fetch_count + COUNT_SIZE'(1);
      end else if (invalidate) begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end
      if (bus.redirect_valid_i && (bus.redirect_pc_i[1:0] != 2'b00))
        misalign <= 1'b1;
    end
  end

  assign bus.pc_o             = pc;
  assign bus.if_id_valid_o    = if_id_valid;
  assign bus.if_id_instr_o    = if_id_instr;
  assign bus.if_id_pc_o       = if_id_pc;
  assign bus.if_id_pc_plus4_o = if_id_pc_plus4;
  assign bus.halted_o         = halted;
  assign bus.misalign_o       = misalign;
  assign bus.fetch_count_o    = fetch_count;

endmodule
